// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

    // Default bit timing: 50 MHz system clock at 115200 baud.
    localparam int unsigned UART_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Baud counter: free-runs from 0 to CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_tx_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CntW   = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Terminal count marks the final cycle of the current bit period.
    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, serialised as start, data LSB-first,
// optional parity and stop bit(s). The line output comes straight from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // One index counter serves both data bits and stop bits.
    localparam int unsigned     IdxW     = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 baud_clr;
    logic                 baud_tick;

    // Held in clear while idle so the start bit always gets a full period; every
    // later bit/state change lands on a terminal count, where the counter wraps.
    assign baud_clr = (state_q == IDLE);

    uart_tx_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    // Next-state logic: frame sequencing, bit indexing and byte capture.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LastData) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_idx_q == LastStop) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                bit_idx_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so tx changes in the same cycle as the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[bit_idx_d];
            PARITY:  tx_d = (^shift_q) ^ 1'(PARITY_ODD);
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        tx_done_d = (state_q == STOP) && (state_d == IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity, even parity, odd parity) at
// 4 clocks per bit sharing one stimulus stream.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] tx_w, rdy_w, busy_w, done_w;

    int vectors;
    int miscompares;

    uart_tx #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
    );

    uart_tx #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
    );

    uart_tx #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int d);
        return (d == 0) ? 40 : 44;
    endfunction

    // Expected line level k cycles after the first start-bit cycle.
    function automatic logic exp_tx(input int d, input logic [7:0] data, input logic pbit,
                                    input int k);
        int b;
        b = k / 4;
        if (k >= frame_len(d)) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (d != 0 && b == 9) return pbit;
        return 1'b1;
    endfunction

    task automatic chk_cycle(input int d, input logic [7:0] data, input logic pbit,
                             input int k);
        int len;
        len = frame_len(d);
        check($sformatf("d%0d k%0d tx", d, k), tx_w[d], exp_tx(d, data, pbit, k));
        check($sformatf("d%0d k%0d ready", d, k), rdy_w[d], k >= len);
        check($sformatf("d%0d k%0d busy", d, k), busy_w[d], k < len);
        check($sformatf("d%0d k%0d done", d, k), done_w[d], k == len);
    endtask

    // Checks all three instances for n cycles; p1/p2 are the even/odd parity bits.
    task automatic frame_check(input logic [7:0] data, input logic p1, input logic p2,
                               input int n);
        for (int k = 0; k < n; k++) begin
            for (int d = 0; d < 3; d++) begin
                chk_cycle(d, data, (d == 1) ? p1 : p2, k);
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] data);
        tx_data  = data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s d%0d tx", tag, d), tx_w[d], 1'b1);
            check($sformatf("%s d%0d ready", tag, d), rdy_w[d], 1'b1);
            check($sformatf("%s d%0d busy", tag, d), busy_w[d], 1'b0);
            check($sformatf("%s d%0d done", tag, d), done_w[d], 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        tick();
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            idle_check($sformatf("idle%0d", i));
            tick();
        end

        // 0xA5: four ones, even parity 0, odd parity 1.
        send(8'hA5);
        frame_check(8'hA5, 1'b0, 1'b1, 50);

        // 0x07: three ones, even parity 1, odd parity 0.
        send(8'h07);
        frame_check(8'h07, 1'b1, 1'b0, 50);

        // Back-to-back with tx_valid held high, checked on the no-parity instance.
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h0F;
        for (int k = 0; k <= 40; k++) begin
            chk_cycle(0, 8'h55, 1'b0, k);
            tick();
        end
        for (int k = 0; k < 45; k++) begin
            if (k == 39) tx_valid = 1'b0;
            chk_cycle(0, 8'h0F, 1'b0, k);
            tick();
        end

        // tx_data changes mid-frame; 0x3C must still be serialised.
        do_reset();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        frame_check(8'h3C, 1'b0, 1'b1, 50);

        // Reset during data bit 3 (cycles 16..19 after the start bit begins).
        send(8'hA5);
        frame_check(8'hA5, 1'b0, 1'b1, 18);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle_check($sformatf("post_rst%0d", i));
            tick();
        end
        send(8'h5A);
        frame_check(8'h5A, 1'b0, 1'b1, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: the transmit-side counterpart of the team's UART receive path.
- Accepts a parallel byte over a valid/ready handshake and serialises it as start bit, data LSB-first, optional parity, and stop bit(s) on a single line.
- Bit timing comes from an internal baud counter clocked by the system clock.
- Sits between the host-side data source and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 434, system clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal 5..8.
- PARITY_EN, 0, 1 = insert parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to send; sampled only at handshake.
- tx_valid  in  1  source has data on tx_data.
- tx_ready  out  1  transmitter can accept a byte (high only in IDLE).
- tx  out  1  serial line; idle level 1.
- tx_busy  out  1  frame in progress (inverse of tx_ready).
- tx_done  out  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (rst_n = 0 at a rising edge, synchronous): state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, counters = 0. Applies mid-frame too: the frame is abandoned, and tx = 1 from the cycle after the reset edge. No partial frame resumes.
- Handshake: a byte is accepted on the rising edge where tx_valid && tx_ready. tx_data is copied into a shift register at that edge. tx_data and tx_valid are don't-care while tx_busy = 1.
- FSM states: IDLE → START → DATA → PARITY (only if PARITY_EN) → STOP → IDLE.
- IDLE: tx = 1. On accept, go to START; from the next cycle tx = 0, tx_ready = 0, tx_busy = 1.
- Bit timing: each state holds tx for exactly CLKS_PER_BIT cycles using a baud counter of width $clog2(CLKS_PER_BIT). The counter clears on every state or bit change.
- DATA: tx = shift_reg[bit_idx], bit_idx from 0 to DATA_BITS-1 (LSB first). Advance bit_idx on each baud-counter terminal count; leave DATA after index DATA_BITS-1.
- PARITY: tx = ^data_latched ^ PARITY_ODD, where data_latched holds the DATA_BITS accepted.
- STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. At terminal count, go to IDLE.
- tx_done: asserted for exactly one cycle, the first IDLE cycle after STOP. tx_ready = 1 in that same cycle.
- Back-to-back: if tx_valid is high in that first IDLE cycle, the next byte is accepted there. The next start bit begins one cycle later, so inter-frame gap = 1 clk of idle-high.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- tx is driven directly from a flop; no combinational path from tx_data or tx_valid to tx.
- tx_valid held high during a frame causes no extra accept; exactly one byte per frame.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Default constants UART_CLKS_PER_BIT = 434 and UART_DATA_BITS = 8, shared with the receive side.
- One sub-module, uart_tx_baud_cnt: baud counter with CLKS_PER_BIT parameter, clear input, and a terminal-count (tick) output.
- The FSM, shift register and parity generation stay in uart_tx.

Test Plan (CLKS_PER_BIT = 4, DATA_BITS = 8 unless stated):
- Reset then idle for 20 clk → tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0 throughout.
- Send 0xA5, no parity → tx sequence per 4 clk: 0, 1,0,1,0,0,1,0,1, 1. tx_done pulses once, 40 clk after the first start cycle. tx_ready stays 0 for the whole 40 clk.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x07 → parity bit = 1, frame = 44 clk. With PARITY_ODD = 1 → parity bit = 0.
- tx_valid held high with 0x55 then 0x0F → two frames separated by exactly 1 idle-high clk. Second frame's data bits are 1,1,1,1,0,0,0,0.
- Change tx_data from 0x3C to 0xFF in the middle of a frame → serialised data is still 0x3C.
- Assert rst_n = 0 for 1 clk during DATA bit 3 → tx = 1 and tx_ready = 1 on the next cycle, no tx_done pulse. A new accept then produces a clean full frame.
